// File: rtl/lector_fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lector_fifo_uart_pkg
// Description : Shared constants for the FIFO-to-UART reader: FSM state
//               encoding and UART frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package lector_fifo_uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;   // start + 8 data + stop

    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] c_st_idle    = 3'd0;
    localparam logic [c_state_w-1:0] c_st_read    = 3'd1;
    localparam logic [c_state_w-1:0] c_st_capture = 3'd2;
    localparam logic [c_state_w-1:0] c_st_start   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_data    = 3'd4;
    localparam logic [c_state_w-1:0] c_st_stop    = 3'd5;

endpackage : lector_fifo_uart_pkg
`default_nettype wire

// File: rtl/lector_fifo_uart_if.sv
`default_nettype none
// ============================================================================
// Module      : lector_fifo_uart_if
// Description : FIFO read handshake plus UART line/status signals.
//   enable    : permission to start draining a new word
//   empty     : FIFO empty flag
//   dato_in   : FIFO read data, valid the cycle after rd_en
//   rd_en     : FIFO read strobe, one cycle per word
//   tx        : UART serial line, idle high
//   busy      : reader is not idle
//   word_done : one-cycle pulse after the last stop bit of a word
//   master = the reader block, slave = FIFO/line side
// Revision    : 1.0 - initial release
// ============================================================================
interface lector_fifo_uart_if #(
    parameter int DATA_W = 16
) ();
    logic              enable;
    logic              empty;
    logic [DATA_W-1:0] dato_in;
    logic              rd_en;
    logic              tx;
    logic              busy;
    logic              word_done;

    modport master (
        input  enable, empty, dato_in,
        output rd_en, tx, busy, word_done
    );

    modport slave (
        output enable, empty, dato_in,
        input  rd_en, tx, busy, word_done
    );
endinterface : lector_fifo_uart_if
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises tick
//               on the last count, reloading to 0 at every bit boundary.
//   clk, rst  : system clock, synchronous active-high reset
//   clear     : hold the counter at 0 (no tick while asserted)
//   tick      : high in the last cycle of each bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      tick
);
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign tick = (r_count == c_last) && !clear;

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/lector_fifo_uart.sv
`default_nettype none
// ============================================================================
// Module      : lector_fifo_uart
// Description : Pops 16-bit words from a FIFO and sends each as two 8N1 UART
//               frames, high byte first, back-to-back.
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : lector_fifo_uart_if.master (enable, empty, dato_in in;
//               rd_en, tx, busy, word_done out)
// Revision    : 1.0 - initial release
// ============================================================================
module lector_fifo_uart
    import lector_fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lector_fifo_uart_if.master bus
);
    logic [c_state_w-1:0] r_state;
    logic                 r_sel;       // 0 = high byte on the line, 1 = low byte
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic [DATA_W-1:0]    r_shadow;
    logic                 r_tx;
    logic                 r_rd_en;
    logic                 r_busy;
    logic                 r_word_done;

    logic                 w_tick;
    logic                 w_timer_clear;
    logic [7:0]           w_cur_byte;

    // The timer only runs while a frame is on the line, so every START
    // entered from CAPTURE begins at count 0.
    assign w_timer_clear = (r_state == c_st_idle) || (r_state == c_st_read) ||
                           (r_state == c_st_capture);

    assign w_cur_byte = r_sel ? r_shadow[7:0] : r_shadow[DATA_W-1 -: 8];

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_sel       <= 1'b0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_shadow    <= '0;
            r_tx        <= 1'b1;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_rd_en     <= 1'b0;
            r_word_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.enable && !bus.empty) begin
                        r_state <= c_st_read;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_read: begin
                    r_state <= c_st_capture;
                end
                c_st_capture: begin
                    // Data is frozen here; later FIFO activity cannot disturb it.
                    r_shadow <= bus.dato_in;
                    r_sel    <= 1'b0;
                    r_tx     <= 1'b0;
                    r_state  <= c_st_start;
                end
                c_st_start: begin
                    if (w_tick) begin
                        r_tx      <= w_cur_byte[0];
                        r_shift   <= {1'b0, w_cur_byte[7:1]};
                        r_bit_idx <= '0;
                        r_state   <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            r_tx    <= 1'b1;
                            r_state <= c_st_stop;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                c_st_stop: begin
                    if (w_tick) begin
                        if (!r_sel) begin
                            // Second frame follows with no idle gap.
                            r_sel   <= 1'b1;
                            r_tx    <= 1'b0;
                            r_state <= c_st_start;
                        end else begin
                            r_state     <= c_st_idle;
                            r_busy      <= 1'b0;
                            r_word_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.tx        = r_tx;
    assign bus.busy      = r_busy;
    assign bus.word_done = r_word_done;

endmodule : lector_fifo_uart
`default_nettype wire

// File: tb/tb_lector_fifo_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_lector_fifo_uart
// Description : Self-checking bench for lector_fifo_uart. A FIFO model feeds
//               words and pushes the expected bytes to a scoreboard; a UART
//               receiver model pops and compares each received frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lector_fifo_uart;
    import lector_fifo_uart_pkg::*;

    localparam int CPB      = 4;
    localparam int WORD_CYC = 2 * UART_FRAME_BITS * CPB;
    localparam int CPB_LONG = 868;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lector_fifo_uart_if #(.DATA_W(16)) u_if  ();
    lector_fifo_uart_if #(.DATA_W(16)) u_if2 ();

    lector_fifo_uart #(.CLKS_PER_BIT(CPB), .DATA_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    lector_fifo_uart #(.CLKS_PER_BIT(CPB_LONG), .DATA_W(16)) u_dut_long (
        .clk (clk),
        .rst (rst),
        .bus (u_if2)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [15:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int         rd_count   = 0;
    int         done_count = 0;
    int         rd_cyc     = 0;
    int         word_fall  = 0;
    int         done_cyc   = 0;
    int         hold       = 0;
    bit         expect_first = 0;
    bit         mon_en       = 1;
    bit         b2b_check    = 0;
    logic       prev_rd   = 1'b0;
    logic       prev_done = 1'b0;
    logic [15:0] fw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(done_count >= target), 1);
    endtask

    task automatic wait_rd(input int target, input int budget);
        int n = 0;
        while (rd_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rd_wait", 32'(rd_count >= target), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after rd_en, then goes to junk.
    always @(negedge clk) begin
        if (u_if.rd_en === 1'b1) begin
            check("rd_nonempty", 32'(fifo_q.size() != 0), 1);
            check("rd_single", 32'(prev_rd), 0);
            rd_count++;
            rd_cyc       = cyc;
            expect_first = 1;
            if (fifo_q.size() != 0) begin
                fw = fifo_q.pop_front();
                u_if.dato_in = fw;
                exp_q.push_back(fw[15:8]);
                exp_q.push_back(fw[7:0]);
            end
            hold = 1;
        end else if (hold > 0) begin
            hold--;
        end else begin
            u_if.dato_in = 16'($urandom);
        end
        prev_rd = u_if.rd_en;
        u_if.empty = (fifo_q.size() == 0);
    end

    // word_done monitor
    always @(negedge clk) begin
        if (u_if.word_done === 1'b1) begin
            check("done_single", 32'(prev_done), 0);
            if (mon_en) check("word_len", 32'(cyc - word_fall), WORD_CYC);
            done_cyc = cyc;
            done_count++;
        end
        prev_done = u_if.word_done;
    end

    // UART receiver: samples each bit mid-period.
    initial begin : g_uart_rx
        logic [7:0] b;
        logic       start_b;
        logic       stop_b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (u_if.tx === 1'b0) begin
                if (mon_en && expect_first) begin
                    check("fall_latency", 32'(cyc - rd_cyc), 2);
                    if (b2b_check) check("b2b_gap", 32'(cyc - done_cyc), 3);
                    word_fall    = cyc;
                    expect_first = 0;
                end
                repeat (2) @(negedge clk);
                start_b = u_if.tx;
                for (int i = 0; i < UART_DATA_BITS; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = u_if.tx;
                end
                repeat (CPB) @(negedge clk);
                stop_b = u_if.tx;
                if (mon_en) begin
                    check("start_bit", 32'(start_b), 0);
                    check("stop_bit", 32'(stop_b), 1);
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", 32'(b), 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(b), 32'(e));
                    end
                end
            end
        end
    end

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : g_stim
        int base;
        int bad;
        int n;
        int fall2;
        int done2;

        u_if.enable  = 1'b0;
        u_if.empty   = 1'b1;
        u_if.dato_in = '0;
        u_if2.enable  = 1'b0;
        u_if2.empty   = 1'b1;
        u_if2.dato_in = 16'h5A5A;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(u_if.tx), 1);
        check("rst_busy", 32'(u_if.busy), 0);
        check("rst_rd_en", 32'(u_if.rd_en), 0);
        check("rst_word_done", 32'(u_if.word_done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word 0xA53C
        fifo_q.push_back(16'hA53C);
        u_if.enable = 1'b1;
        wait_done(1, 300);
        repeat (10) @(negedge clk);
        check("single_rd_count", 32'(rd_count), 1);
        check("single_done_count", 32'(done_count), 1);
        check("single_sb_empty", 32'(exp_q.size()), 0);

        // Empty FIFO with enable held high
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0 || u_if.rd_en !== 1'b0) bad++;
        end
        check("empty_idle_bad_cycles", 32'(bad), 0);
        check("empty_rd_count", 32'(rd_count), 1);

        // Back-to-back words
        base = rd_count;
        fifo_q.push_back(16'h0001);
        fifo_q.push_back(16'hFFFF);
        wait_rd(base + 1, 50);
        repeat (10) @(negedge clk);
        b2b_check = 1;
        wait_done(done_count + 2, 400);
        b2b_check = 0;
        repeat (5) @(negedge clk);
        check("b2b_rd_count", 32'(rd_count), 32'(base + 2));
        check("b2b_sb_empty", 32'(exp_q.size()), 0);

        // Enable dropped during the high-byte data bits
        base = rd_count;
        n = done_count;
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'hBEEF);
        wait_rd(base + 1, 50);
        repeat (12) @(negedge clk);
        u_if.enable = 1'b0;
        wait_done(n + 1, 300);
        repeat (30) @(negedge clk);
        check("drop_rd_count", 32'(rd_count), 32'(base + 1));
        check("drop_fifo_left", 32'(fifo_q.size()), 1);
        check("drop_busy", 32'(u_if.busy), 0);
        check("drop_sb_empty", 32'(exp_q.size()), 0);
        u_if.enable = 1'b1;
        wait_done(n + 2, 300);
        repeat (5) @(negedge clk);
        check("drop_resume_sb_empty", 32'(exp_q.size()), 0);

        // Reset during bit 3 of the low byte
        base = rd_count;
        n = done_count;
        fifo_q.push_back(16'hC3A1);
        fifo_q.push_back(16'h5E77);
        wait_rd(base + 1, 50);
        u_if.enable = 1'b0;
        bad = 0;
        while (cyc < rd_cyc + 2 + 57 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        mon_en = 0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(u_if.tx), 1);
        check("midrst_busy", 32'(u_if.busy), 0);
        check("midrst_rd_en", 32'(u_if.rd_en), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_rd", 32'(rd_count), 32'(base + 1));
        check("midrst_no_done", 32'(done_count), 32'(n));
        check("midrst_tx_idle", 32'(u_if.tx), 1);
        exp_q.delete();
        mon_en = 1;
        u_if.enable = 1'b1;
        wait_done(n + 1, 300);
        repeat (5) @(negedge clk);
        check("midrst_rd_after", 32'(rd_count), 32'(base + 2));
        check("midrst_sb_empty", 32'(exp_q.size()), 0);
        u_if.enable = 1'b0;

        // Full-rate timing with CLKS_PER_BIT = 868
        fall2 = -1;
        done2 = -1;
        u_if2.empty  = 1'b0;
        u_if2.enable = 1'b1;
        n = 0;
        while (done2 < 0 && n < 20000) begin
            @(negedge clk);
            n++;
            if (u_if2.rd_en === 1'b1) u_if2.empty = 1'b1;
            if (u_if2.tx === 1'b0 && fall2 < 0) fall2 = cyc;
            if (u_if2.word_done === 1'b1) done2 = cyc;
        end
        check("long_done_seen", 32'(done2 >= 0), 1);
        check("long_word_cycles", 32'(done2 - fall2), 32'(20 * CPB_LONG));
        u_if2.enable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lector_fifo_uart
`default_nettype wire
